// File: rtl/vm_pkg.sv
// Shared definitions for the parametrised juice vending machine: coin codes,
// coin-to-credit conversion and the controller state encoding.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  typedef enum logic {ST_COLLECT, ST_CHANGE} state_t;

  // Credit value of a coin code in 5 Rs units; invalid codes are worth nothing.
  function automatic logic [1:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_5:  return 2'd1;
      COIN_10: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_param_if.sv
// Coin-acceptor / actuator bundle of the vending machine. The master side
// drives coins and cancel; the slave (the machine) drives the result pulses.
interface vending_machine_param_if #(
  parameter int CREDIT_W = 4
);
  logic [1:0]          coin;
  logic                cancel;
  logic                J;
  logic                R;
  logic                N;
  logic                chg;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (output coin, cancel, input J, R, N, chg, busy, credit);
  modport slave  (input coin, cancel, output J, R, N, chg, busy, credit);
endinterface

// File: rtl/vm_idle_timer.sv
// Loadable idle down-counter: reloaded by load, counts while run is high and
// pulses expire on the run cycle after it has reached zero.
module vm_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] TOP = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= TOP;
    else if (load)                 cnt_q <= TOP;
    else if (run && cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign expire = run && !load && (cnt_q == '0);
endmodule

// File: rtl/vending_machine_param.sv
// Parametrised juice vending controller: collects 5/10 Rs coins against
// PRICE_UNITS, vends, and pays surplus or refunds as serial chg pulses.
// Optional idle auto-refund is enabled with `define VM_TIMEOUT_EN.
module vending_machine_param
  import vm_pkg::*;
#(
  parameter int PRICE_UNITS    = 3,
  parameter int CREDIT_W       = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                    clk,
  input logic                    rst,
  vending_machine_param_if.slave vm
);
  localparam logic [CREDIT_W:0] PRICE = (CREDIT_W + 1)'(PRICE_UNITS);

  if (PRICE_UNITS < 2 || PRICE_UNITS > (2 ** CREDIT_W) - 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("vending_machine_param: illegal PRICE_UNITS/CREDIT_W/TIMEOUT_CYCLES");
  end

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                j_q, j_d, r_q, r_d, n_q, n_d, chg_q, chg_d;
  logic [CREDIT_W:0]   sum, diff;
  logic                cancel_eff;

`ifdef VM_TIMEOUT_EN
  logic idle_run, idle_load, expire;

  // Idle time only accumulates while credit is parked and nothing happens.
  assign idle_run  = (state_q == ST_COLLECT) && (credit_q != '0);
  assign idle_load = !idle_run || (vm.coin != COIN_NONE) || vm.cancel;

  vm_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst),
    .load   (idle_load),
    .run    (idle_run),
    .expire (expire)
  );

  assign cancel_eff = vm.cancel | expire;
`else
  assign cancel_eff = vm.cancel;
`endif

  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    j_d      = 1'b0;
    r_d      = 1'b0;
    n_d      = 1'b0;
    chg_d    = 1'b0;
    sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_units(vm.coin));
    diff     = sum - PRICE;

    case (state_q)
      ST_COLLECT: begin
        if (cancel_eff) begin
          r_d = (vm.coin != COIN_NONE);
          if (credit_q != '0) begin
            change_d = credit_q;
            credit_d = '0;
            state_d  = ST_CHANGE;
          end
        end else if (vm.coin == COIN_BAD) begin
          r_d = 1'b1;
        end else if (vm.coin != COIN_NONE) begin
          if (sum >= PRICE) begin
            j_d      = 1'b1;
            credit_d = '0;
            change_d = diff[CREDIT_W-1:0];
            if (diff != '0) state_d = ST_CHANGE;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            n_d      = 1'b1;
          end
        end
      end

      // The vend/refund cycle itself emits no pulse; coins stay rejected
      // until the edge after the last pulse has been seen.
      ST_CHANGE: begin
        r_d = (vm.coin != COIN_NONE);
        if (change_q != '0) begin
          chg_d    = 1'b1;
          change_d = change_q - CREDIT_W'(1);
        end else begin
          state_d = ST_COLLECT;
        end
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_COLLECT;
      credit_q <= '0;
      change_q <= '0;
      j_q      <= 1'b0;
      r_q      <= 1'b0;
      n_q      <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      j_q      <= j_d;
      r_q      <= r_d;
      n_q      <= n_d;
      chg_q    <= chg_d;
    end
  end

  assign vm.J      = j_q;
  assign vm.R      = r_q;
  assign vm.N      = n_q;
  assign vm.chg    = chg_q;
  assign vm.busy   = chg_q;
  assign vm.credit = credit_q;
endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the team's 5/10 Rs juice vending FSM.
- Accumulates coin credit against a configurable price (in 5 Rs units), vends when credit reaches the price, and returns surplus as serial change pulses.
- Supports a cancel/refund request and reports live credit.
- Sits between the coin acceptor front-end (synchronised, one-cycle coin codes) and the dispense/refund actuators.

Parameters:
- PRICE_UNITS, 3, product price in 5 Rs units (3 = 15 Rs); legal range 2..(2^CREDIT_W − 2).
- CREDIT_W, 4, width of the credit and change counters.
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund; used only with VM_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- coin  input  2  coin code sampled every clk: 00 none, 01 5 Rs (1 unit), 10 10 Rs (2 units), 11 invalid.
- cancel  input  1  refund request, level sampled each clk.
- J  output  1  juice dispensed, one-cycle pulse.
- R  output  1  coin rejected, one-cycle pulse.
- N  output  1  no juice: valid coin accepted but credit still below price, one-cycle pulse.
- chg  output  1  change/refund pulse; each pulse returns one 5 Rs unit.
- busy  output  1  high while in CHANGE; coins are not credited while busy.
- credit  output  CREDIT_W  current accumulated credit in units.

Behaviour:
- Reset: while rst=0, all outputs are 0, credit=0, change count=0, state=COLLECT.
- Registered outputs: J/R/N/chg respond in the cycle after the sampling edge.
- States:
  - COLLECT: accumulates coins.
  - CHANGE: emits queued change; busy=1 for exactly the cycles in which chg=1.
- COLLECT, coin 01/10, cancel=0:
  - sum = credit + value.
  - If sum ≥ PRICE_UNITS: J=1, credit←0, change←sum−PRICE_UNITS; go to CHANGE if the change count is nonzero, else stay in COLLECT.
  - Otherwise: credit←sum, N=1.
- COLLECT, coin 11: R=1; credit unchanged.
- COLLECT, coin 00, cancel=0: no outputs; credit holds.
- COLLECT, cancel=1:
  - If credit>0: change←credit, credit←0, go to CHANGE, no J.
  - If credit=0: no effect.
  - If coin≠00 in the same cycle: cancel wins and R=1; the coin is not credited.
- CHANGE:
  - chg=1 for each cycle; change count decrements per pulse.
  - Return to COLLECT after the last pulse.
  - Any coin≠00 gives R=1 and is not credited.
  - cancel is ignored.
- Change bounds: maximum vend change is 1 unit (credit PRICE−1 plus a 10 Rs coin). Maximum refund is PRICE_UNITS−1 units. No counter overflow is possible within the legal PRICE_UNITS range.
- Reset mid-CHANGE: pending change is discarded, with no further chg pulses. Credit is lost by design.
- Exact-price case: sum = PRICE gives J only, no CHANGE state, and the machine accepts a coin on the very next cycle.

Optional Feature:
- VM_TIMEOUT_EN defined:
  - An idle counter runs in COLLECT while credit>0.
  - The counter resets on any valid or invalid coin, or on cancel.
  - On reaching TIMEOUT_CYCLES, the machine behaves as cancel: refunds the full credit via CHANGE.
- VM_TIMEOUT_EN undefined: no counter exists; credit is held indefinitely. TIMEOUT_CYCLES is unused.

Decomposition:
- Package vm_pkg holds:
  - Coin code constants: COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10, COIN_BAD=2'b11.
  - Unit-value function (code → units).
  - State enum {ST_COLLECT, ST_CHANGE}.
- One natural sub-module: vm_idle_timer, a loadable down-counter with expiry pulse, instantiated only under VM_TIMEOUT_EN.

Test Plan (PRICE_UNITS=3):
- Reset: hold rst=0 with random coin/cancel → all outputs 0, credit=0. Release → first coin is accepted normally.
- Sequence 01,10: after 01 → N=1, credit=1. After 10 → J=1 one cycle, chg never asserts, credit=0.
- Sequence 10,10: after 2nd coin → J=1. Next cycle → chg=1 and busy=1 for exactly 1 cycle, then busy=0, credit=0.
- Sequence 01,01,cancel: → N pulses twice, credit=2. After cancel → chg=1 for 2 consecutive cycles, no J. A coin 01 during those cycles gives R=1 and credit stays 0.
- Coin 11 with credit=1 → R=1 one cycle, credit stays 1, J=N=0. Same-cycle cancel+01 with credit=1 → R=1, one chg pulse.
- VM_TIMEOUT_EN with TIMEOUT_CYCLES=8: coin 01 then idle for 8 cycles → one chg pulse, credit=0. A coin at cycle 7 restarts the timer. Asserting rst=0 during CHANGE stops chg immediately.
